// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch unit and
// instruction memory.
//   imem_req    fetch request, held high until imem_ack
//   imem_addr   fetch address, stable while imem_req is high
//   imem_ack    response strobe; imem_rdata valid in the same cycle
//   imem_rdata  fetched instruction word
// Modports: master = fetch unit, slave = instruction memory.
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, fetches
// over a variable-latency req/ack bus, keeps one extra response in a skid
// register so a downstream stall never drops an instruction, and handles
// redirects including squashing a fetch that is already in flight.
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   imem         instruction-memory bus (master side)
//   stall        downstream not accepting this cycle
//   redirect     one-cycle flush-and-jump strobe
//   redirect_pc  jump target, sampled with redirect
//   if_valid     output slot holds a live instruction
//   if_inst      instruction (0 when not valid)
//   if_pc        address of if_inst
//   if_pc_4      if_pc + 4 (mod 2^32)
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_unit_if.master    imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [31:0]        if_inst,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_4
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc;
    // Address of a squashed fetch still owed an ack; pc already holds the
    // redirect target, so the bus must keep presenting this one.
    logic [31:0] drain_addr;
    logic        skid_vld;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;

    logic xfer;
    logic slot_free;

    assign xfer      = if_valid && !stall;
    assign slot_free = !if_valid || xfer;

    assign imem.imem_req  = (state == REQ) || (state == DRAIN);
    assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= '0;
            if_valid   <= 1'b0;
            if_inst    <= '0;
            if_pc      <= '0;
            if_pc_4    <= '0;
            skid_vld   <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (redirect) begin
            // Redirect beats stall and ack: everything fetched so far is stale.
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            if_inst  <= '0;
            skid_vld <= 1'b0;
            case (state)
                REQ: begin
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end else begin
                        state      <= DRAIN;
                        drain_addr <= pc;
                    end
                end
                DRAIN:   state <= imem.imem_ack ? REQ : DRAIN;
                default: state <= REQ;
            endcase
        end else begin
            // A transfer empties the slot unless a refill below overrides it.
            if (xfer) begin
                if_valid <= 1'b0;
                if_inst  <= '0;
            end
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem.imem_ack) begin
                        if (slot_free) begin
                            pc       <= pc + 32'd4;
                            if_valid <= 1'b1;
                            if_inst  <= imem.imem_rdata;
                            if_pc    <= pc;
                            if_pc_4  <= pc + 32'd4;
                        end else if (!skid_vld) begin
                            pc        <= pc + 32'd4;
                            skid_vld  <= 1'b1;
                            skid_inst <= imem.imem_rdata;
                            skid_pc   <= pc;
                            state     <= FULL;
                        end
                    end
                end
                FULL: begin
                    // No request is issued here, so nothing can arrive while
                    // both entries are occupied.
                    if (xfer) begin
                        if (skid_vld) begin
                            if_valid <= 1'b1;
                            if_inst  <= skid_inst;
                            if_pc    <= skid_pc;
                            if_pc_4  <= skid_pc + 32'd4;
                        end
                        skid_vld <= 1'b0;
                        state    <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ack) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. Each scenario pushes the PCs it expects
// to see delivered onto a scoreboard queue; a monitor pops and compares on
// every transfer. Instruction memory returns a fixed function of the address
// with a programmable ack latency.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;

    logic        ack_en = 1'b0;
    logic        force_ack = 1'b0;
    int          lat = 1;
    int          cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];

    logic [31:0] t2_addr [10] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4,
                                  32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
    logic        t2_vld  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    if_fetch_unit_if bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc_4     (if_pc_4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Memory: ack after lat cycles of continuous request (lat=1 -> same cycle).
    always @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= 0;
        else if (bus.imem_req && !bus.imem_ack)
            cnt <= cnt + 1;
        else
            cnt <= 0;
    end

    assign bus.imem_ack   = force_ack | (ack_en & bus.imem_req & (cnt >= lat - 1));
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        stall     = 1'b0;
        redirect  = 1'b0;
        force_ack = 1'b0;
        ack_en    = 1'b0;
        lat       = 1;
        step(2);
        rst = 1'b0;
    endtask

    // Monitor: a transfer happens on the next rising edge when valid && !stall.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && if_valid && !stall && !redirect) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h expected none", if_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", if_pc, e);
                    chk("sb_inst", if_inst, mem_word(e));
                    chk("sb_pc_4", if_pc_4, e + 32'd4);
                end
            end else if (!if_valid) begin
                chk("nop_inst", if_inst, 32'h0);
            end
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc_4", if_pc_4, 32'h0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait memory, no stall
        ack_en = 1'b1;
        lat = 1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        sb_q.push_back(32'h8); sb_q.push_back(32'hC);
        chk("s1_idle_req", {31'b0, bus.imem_req}, 32'h0);
        step(1);
        chk("s1_addr0", bus.imem_addr, 32'h0);
        chk("s1_valid0", {31'b0, if_valid}, 32'h0);
        step(1);
        chk("s1_valid1", {31'b0, if_valid}, 32'h1);
        chk("s1_addr4", bus.imem_addr, 32'h4);
        step(1);
        chk("s1_addr8", bus.imem_addr, 32'h8);
        step(1);
        chk("s1_addrC", bus.imem_addr, 32'hC);
        step(1);
        ack_en = 1'b0;
        step(3);
        chk("s1_drained", sb_q.size(), 32'h0);

        // Latency 3
        do_reset();
        ack_en = 1'b1;
        lat = 3;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("s2_addr", bus.imem_addr, t2_addr[k]);
            chk("s2_valid", {31'b0, if_valid}, {31'b0, t2_vld[k]});
        end
        ack_en = 1'b0;
        step(3);
        chk("s2_drained", sb_q.size(), 32'h0);

        // Stall with skid fill
        do_reset();
        ack_en = 1'b1;
        lat = 1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4);
        sb_q.push_back(32'h8); sb_q.push_back(32'hC);
        step(3);
        stall = 1'b1;
        chk("s3_pc_hold0", if_pc, 32'h4);
        step(1);
        chk("s3_full_req", {31'b0, bus.imem_req}, 32'h0);
        chk("s3_pc_hold1", if_pc, 32'h4);
        chk("s3_valid", {31'b0, if_valid}, 32'h1);
        step(3);
        chk("s3_pc_hold2", if_pc, 32'h4);
        chk("s3_full_req2", {31'b0, bus.imem_req}, 32'h0);
        stall = 1'b0;
        step(1);
        chk("s3_skid_out", if_pc, 32'h8);
        chk("s3_req_again", {31'b0, bus.imem_req}, 32'h1);
        chk("s3_addrC", bus.imem_addr, 32'hC);
        step(1);
        chk("s3_pcC", if_pc, 32'hC);
        ack_en = 1'b0;
        step(3);
        chk("s3_drained", sb_q.size(), 32'h0);

        // Redirect during an outstanding fetch
        do_reset();
        ack_en = 1'b1;
        lat = 1;
        sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
        sb_q.push_back(32'hC); sb_q.push_back(32'h100);
        step(5);
        chk("s4_addr10", bus.imem_addr, 32'h10);
        lat = 4;
        step(1);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        redirect = 1'b0;
        chk("s4_drain_req", {31'b0, bus.imem_req}, 32'h1);
        chk("s4_drain_addr0", bus.imem_addr, 32'h10);
        chk("s4_drain_vld0", {31'b0, if_valid}, 32'h0);
        step(1);
        chk("s4_drain_addr1", bus.imem_addr, 32'h10);
        chk("s4_drain_vld1", {31'b0, if_valid}, 32'h0);
        lat = 1;
        step(1);
        chk("s4_new_addr", bus.imem_addr, 32'h100);
        chk("s4_vld_after", {31'b0, if_valid}, 32'h0);
        step(1);
        chk("s4_first_pc", if_pc, 32'h100);
        ack_en = 1'b0;
        step(3);
        chk("s4_drained", sb_q.size(), 32'h0);

        // Redirect with stall, skid full and an ack strobe
        do_reset();
        ack_en = 1'b1;
        lat = 1;
        sb_q.push_back(32'h200);
        step(2);
        stall = 1'b1;
        step(1);
        chk("s5_full_req", {31'b0, bus.imem_req}, 32'h0);
        chk("s5_out_pc", if_pc, 32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        force_ack = 1'b1;
        step(1);
        redirect = 1'b0;
        force_ack = 1'b0;
        chk("s5_flush_vld", {31'b0, if_valid}, 32'h0);
        chk("s5_flush_inst", if_inst, 32'h0);
        chk("s5_req", {31'b0, bus.imem_req}, 32'h1);
        chk("s5_addr", bus.imem_addr, 32'h200);
        stall = 1'b0;
        step(1);
        chk("s5_pc", if_pc, 32'h200);
        ack_en = 1'b0;
        step(3);
        chk("s5_drained", sb_q.size(), 32'h0);

        // Reset while draining
        do_reset();
        ack_en = 1'b1;
        lat = 1;
        step(2);
        stall = 1'b1;
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect = 1'b0;
        chk("s6_drain_addr", bus.imem_addr, 32'h4);
        chk("s6_drain_req", {31'b0, bus.imem_req}, 32'h1);
        chk("s6_pc_4_pre", if_pc_4, 32'h4);
        rst = 1'b1;
        #1;
        chk("s6_rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("s6_rst_addr", bus.imem_addr, 32'h0);
        chk("s6_rst_pc_4", if_pc_4, 32'h0);
        chk("s6_rst_inst", if_inst, 32'h0);
        chk("s6_rst_vld", {31'b0, if_valid}, 32'h0);
        step(1);
        rst = 1'b0;
        stall = 1'b0;
        lat = 1;
        ack_en = 1'b0;
        force_ack = 1'b1;
        sb_q.push_back(32'h0);
        chk("s6_idle_req", {31'b0, bus.imem_req}, 32'h0);
        step(1);
        force_ack = 1'b0;
        ack_en = 1'b1;
        chk("s6_idle_ack_ignored", {31'b0, if_valid}, 32'h0);
        chk("s6_req", {31'b0, bus.imem_req}, 32'h1);
        chk("s6_addr", bus.imem_addr, 32'h0);
        step(1);
        chk("s6_vld", {31'b0, if_valid}, 32'h1);
        chk("s6_pc", if_pc, 32'h0);
        ack_en = 1'b0;
        step(3);
        chk("s6_drained", sb_q.size(), 32'h0);

        // PC wrap-around
        do_reset();
        sb_q.push_back(32'hFFFF_FFFC);
        step(1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        ack_en = 1'b1;
        lat = 1;
        step(1);
        redirect = 1'b0;
        chk("s7_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("s7_vld", {31'b0, if_valid}, 32'h0);
        step(1);
        chk("s7_pc", if_pc, 32'hFFFF_FFFC);
        chk("s7_pc_4", if_pc_4, 32'h0);
        chk("s7_next_addr", bus.imem_addr, 32'h0);
        ack_en = 1'b0;
        step(3);
        chk("s7_drained", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
